dispatch_ctrl: RTL and testbench

DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

---
 rtl/rv32i_types.sv | 42 ++++
 rtl/rs_credit_counter.sv | 31 +++
 rtl/dispatch_ctrl.sv | 101 ++++++++++
 tb/tb_dispatch_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared types for the rename/dispatch front end: reservation-station classes,
// stall reasons, dispatch FSM states and the default reservation-station depth.
package rv32i_types;

    localparam int RS_DEPTH_DEFAULT = 8;
    localparam int NUM_RS           = 5;

    typedef enum logic [2:0] {
        RS_ALU  = 3'd0,
        RS_MUL  = 3'd1,
        RS_DIV  = 3'd2,
        RS_MEM  = 3'd3,
        RS_BR   = 3'd4,
        RS_NONE = 3'd7
    } rs_class_t;

    typedef enum logic [2:0] {
        STALL_NONE     = 3'd0,
        STALL_RS_FULL  = 3'd1,
        STALL_ROB_FULL = 3'd2,
        STALL_FL_EMPTY = 3'd3,
        STALL_FLUSH    = 3'd4
    } stall_cause_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } disp_state_t;

    // Unused encodings map to no station, so they can never win a credit.
    function automatic logic [NUM_RS-1:0] class_onehot(input rs_class_t c);
        case (c)
            RS_ALU:  return 5'b00001;
            RS_MUL:  return 5'b00010;
            RS_DIV:  return 5'b00100;
            RS_MEM:  return 5'b01000;
            RS_BR:   return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/rs_credit_counter.sv
// Free-entry credit for one reservation station: take on dispatch, give on release.
// Saturates at 0 and RS_DEPTH; a release while already full is dropped.
module rs_credit_counter #(
    parameter int RS_DEPTH = 8,
    parameter int CNT_W    = $clog2(RS_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reload,
    input  logic             take,
    input  logic             give,
    output logic [CNT_W-1:0] credit
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(RS_DEPTH);

    always_ff @(posedge clk) begin
        if (rst || reload) begin
            credit <= FULL;
        end else if (take && !give) begin
            if (credit != '0) credit <= credit - CNT_W'(1);
        end else if (give && !take) begin
            if (credit != FULL) credit <= credit + CNT_W'(1);
        end
    end

    // A release with nothing outstanding means the station and this counter disagree.
    assert property (@(posedge clk) disable iff (rst)
        !(give && !take && !reload && credit == FULL));

endmodule

// File: rtl/dispatch_ctrl.sv
// One-entry decode buffer feeding rename/dispatch, gated by ROB, free list and
// per-station credits; flush drops the buffer and refills all credits.
module dispatch_ctrl
    import rv32i_types::*;
#(
    parameter int RS_DEPTH = RS_DEPTH_DEFAULT,
    parameter int CNT_W    = $clog2(RS_DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    input  logic [2:0]  dec_class,
    input  logic        dec_needs_pd,
    output logic        dec_ready,
    input  logic        free_list_empty,
    input  logic        rob_full,
    input  logic [4:0]  rs_free,
    input  logic        jump_commit,
    output logic        disp_valid,
    output logic [2:0]  disp_class,
    output logic [2:0]  stall_cause,
    output logic [31:0] stall_cnt
);

    disp_state_t       state;
    logic              slot_valid;
    rs_class_t         slot_class;
    logic              slot_needs_pd;

    logic [CNT_W-1:0]  credit [NUM_RS];
    logic [NUM_RS-1:0] credit_avail;
    logic [NUM_RS-1:0] cls_hot;
    logic              class_ok;
    logic              stall;
    stall_cause_t      cause;

    assign cls_hot = class_onehot(slot_class);

    for (genvar i = 0; i < NUM_RS; i++) begin : g_rs
        rs_credit_counter #(.RS_DEPTH(RS_DEPTH), .CNT_W(CNT_W)) u_credit (
            .clk    (clk),
            .rst    (rst),
            .reload (jump_commit),
            .take   (disp_valid && cls_hot[i]),
            .give   (rs_free[i]),
            .credit (credit[i])
        );
        assign credit_avail[i] = (credit[i] != '0);
    end

    assign class_ok = (slot_class == RS_NONE) || ((cls_hot & credit_avail) != '0);

    // Outputs are forced idle during reset so nothing leaks from pre-reset state.
    assign disp_valid = !rst && slot_valid && (state == ST_RUN) && !jump_commit && !rob_full
                        && (!slot_needs_pd || !free_list_empty) && class_ok;
    assign dec_ready  = !rst && (state == ST_RUN) && (!slot_valid || disp_valid);
    assign disp_class = disp_valid ? slot_class : RS_NONE;
    assign stall      = !rst && slot_valid && !disp_valid;

    always_comb begin
        cause = STALL_NONE;
        if (stall) begin
            if (jump_commit || state == ST_FLUSH)        cause = STALL_FLUSH;
            else if (rob_full)                           cause = STALL_ROB_FULL;
            else if (slot_needs_pd && free_list_empty)   cause = STALL_FL_EMPTY;
            else                                         cause = STALL_RS_FULL;
        end
    end

    assign stall_cause = cause;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_RUN;
            slot_valid    <= 1'b0;
            slot_class    <= RS_NONE;
            slot_needs_pd <= 1'b0;
            stall_cnt     <= '0;
        end else begin
            if (stall) stall_cnt <= stall_cnt + 32'd1;

            case (state)
                ST_RUN:   if (jump_commit) state <= ST_FLUSH;
                ST_FLUSH: state <= jump_commit ? ST_FLUSH : ST_RUN;
                default:  state <= ST_RUN;
            endcase

            // A handshake in the flush cycle is younger than the jump and is dropped.
            if (jump_commit) begin
                slot_valid <= 1'b0;
            end else if (dec_valid && dec_ready) begin
                slot_valid    <= 1'b1;
                slot_class    <= rs_class_t'(dec_class);
                slot_needs_pd <= dec_needs_pd;
            end else if (disp_valid) begin
                slot_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Table-driven bench for dispatch_ctrl with a dispatch-order scoreboard and
// hand-written sequences for credit saturation, reset and repeated flush.
module tb_dispatch_ctrl;

    localparam logic [2:0] ALU = 3'd0, MUL = 3'd1, MEM = 3'd3, BR = 3'd4, NONE = 3'd7;
    localparam logic [2:0] C_NONE = 3'd0, C_RS = 3'd1, C_FL = 3'd3, C_FLUSH = 3'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid;
    logic [2:0]  dec_class;
    logic        dec_needs_pd;
    logic        dec_ready;
    logic        free_list_empty;
    logic        rob_full;
    logic [4:0]  rs_free;
    logic        jump_commit;
    logic        disp_valid;
    logic [2:0]  disp_class;
    logic [2:0]  stall_cause;
    logic [31:0] stall_cnt;

    int checks   = 0;
    int failures = 0;
    logic [2:0] exp_q[$];
    logic [2:0] sb_exp;

    dispatch_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .dec_valid       (dec_valid),
        .dec_class       (dec_class),
        .dec_needs_pd    (dec_needs_pd),
        .dec_ready       (dec_ready),
        .free_list_empty (free_list_empty),
        .rob_full        (rob_full),
        .rs_free         (rs_free),
        .jump_commit     (jump_commit),
        .disp_valid      (disp_valid),
        .disp_class      (disp_class),
        .stall_cause     (stall_cause),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       dv;
        logic [2:0] cls;
        logic       npd;
        logic       fle;
        logic       robf;
        logic [4:0] free;
        logic       jc;
        logic       e_rdy;
        logic       e_disp;
        logic [2:0] e_cls;
        logic [2:0] e_cause;
        int         e_cnt;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    function automatic vec_t v(input logic dv, input logic [2:0] cls, input logic npd,
                               input logic fle, input logic robf, input logic [4:0] free,
                               input logic jc, input logic er, input logic ed,
                               input logic [2:0] ec, input logic [2:0] ecause, input int ecnt);
        vec_t r;
        r.dv = dv; r.cls = cls; r.npd = npd; r.fle = fle; r.robf = robf; r.free = free;
        r.jc = jc; r.e_rdy = er; r.e_disp = ed; r.e_cls = ec; r.e_cause = ecause; r.e_cnt = ecnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, then sample at the falling edge.
    task automatic step(input logic dv, input logic [2:0] cls, input logic npd, input logic fle,
                        input logic robf, input logic [4:0] free, input logic jc);
        dec_valid = dv; dec_class = cls; dec_needs_pd = npd; free_list_empty = fle;
        rob_full = robf; rs_free = free; jump_commit = jc;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted instruction must come out once, in order, with its class.
    always @(negedge clk) begin
        if (rst || jump_commit) begin
            exp_q.delete();
        end else begin
            if (disp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_dispatch: got class %0d expected no dispatch", disp_class);
                end else begin
                    sb_exp = exp_q.pop_front();
                    chk("sb_class", {29'd0, disp_class}, {29'd0, sb_exp});
                end
            end
            if (dec_valid && dec_ready) exp_q.push_back(dec_class);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = v(1, ALU, 0, 0, 0, 5'b00000, 0,  1, 0, NONE, C_NONE,  0);
        for (int i = 1; i <= 8; i++)
            vecs[i] = v(1, ALU, 0, 0, 0, 5'b00000, 0,  1, 1, ALU, C_NONE, 0);
        vecs[9]  = v(0, ALU, 0, 0, 0, 5'b00000, 0,  0, 0, NONE, C_RS,    0);
        vecs[10] = v(0, ALU, 0, 0, 0, 5'b00001, 0,  0, 0, NONE, C_RS,    1);
        vecs[11] = v(1, MUL, 1, 1, 0, 5'b00000, 0,  1, 1, ALU,  C_NONE,  2);
        vecs[12] = v(0, MUL, 0, 1, 0, 5'b00000, 0,  0, 0, NONE, C_FL,    2);
        vecs[13] = v(0, MUL, 0, 1, 0, 5'b00000, 0,  0, 0, NONE, C_FL,    3);
        vecs[14] = v(0, MUL, 0, 1, 0, 5'b00000, 0,  0, 0, NONE, C_FL,    4);
        vecs[15] = v(1, MEM, 0, 0, 0, 5'b00000, 0,  1, 1, MUL,  C_NONE,  5);
        vecs[16] = v(0, MEM, 0, 0, 1, 5'b00000, 1,  0, 0, NONE, C_FLUSH, 5);
        vecs[17] = v(1, BR,  0, 0, 0, 5'b00000, 0,  0, 0, NONE, C_NONE,  6);
        vecs[18] = v(1, BR,  0, 0, 0, 5'b00000, 0,  1, 0, NONE, C_NONE,  6);
        vecs[19] = v(0, BR,  0, 0, 0, 5'b00000, 0,  1, 1, BR,   C_NONE,  6);

        rst = 1'b1;
        dec_valid = 0; dec_class = ALU; dec_needs_pd = 0; free_list_empty = 0;
        rob_full = 0; rs_free = '0; jump_commit = 0;
        adv();
        @(negedge clk);
        chk("rst_dec_ready",   {31'd0, dec_ready},   0);
        chk("rst_disp_valid",  {31'd0, disp_valid},  0);
        chk("rst_disp_class",  {29'd0, disp_class},  {29'd0, NONE});
        chk("rst_stall_cause", {29'd0, stall_cause}, {29'd0, C_NONE});
        chk("rst_stall_cnt",   stall_cnt,            0);
        adv();
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].dv, vecs[i].cls, vecs[i].npd, vecs[i].fle, vecs[i].robf,
                 vecs[i].free, vecs[i].jc);
            chk($sformatf("row%0d_dec_ready", i),   {31'd0, dec_ready},   {31'd0, vecs[i].e_rdy});
            chk($sformatf("row%0d_disp_valid", i),  {31'd0, disp_valid},  {31'd0, vecs[i].e_disp});
            chk($sformatf("row%0d_disp_class", i),  {29'd0, disp_class},  {29'd0, vecs[i].e_cls});
            chk($sformatf("row%0d_stall_cause", i), {29'd0, stall_cause}, {29'd0, vecs[i].e_cause});
            chk($sformatf("row%0d_stall_cnt", i),   stall_cnt,            vecs[i].e_cnt);
            if (i == 10 || i == 12)
                chk($sformatf("row%0d_alu_credit", i), 32'(dut.g_rs[0].u_credit.credit), 0);
            if (i == 17) begin
                chk("flush_slot_clear",  {31'd0, dut.slot_valid},          0);
                chk("flush_mem_credit",  32'(dut.g_rs[3].u_credit.credit), 8);
                chk("flush_alu_credit",  32'(dut.g_rs[0].u_credit.credit), 8);
            end
            adv();
        end

        // Same-cycle BR dispatch and BR release with 3 credits left.
        step(1, BR, 0, 0, 0, 5'b00000, 0);
        adv();
        for (int k = 0; k < 4; k++) begin
            step(1, BR, 0, 0, 0, 5'b00000, 0);
            chk($sformatf("br_fill%0d_disp", k), {31'd0, disp_valid}, 1);
            adv();
        end
        step(0, BR, 0, 0, 0, 5'b10000, 0);
        chk("br_credit_pre",   32'(dut.g_rs[4].u_credit.credit), 3);
        chk("br_overlap_disp", {31'd0, disp_valid},              1);
        adv();
        chk("br_credit_post",  32'(dut.g_rs[4].u_credit.credit), 3);

        // Reset mid-stream with a buffered ALU and two credits left.
        step(1, ALU, 0, 0, 0, 5'b00000, 0);
        adv();
        for (int k = 0; k < 6; k++) begin
            step(1, ALU, 0, 0, 0, 5'b00000, 0);
            adv();
        end
        chk("pre_rst_alu_credit", 32'(dut.g_rs[0].u_credit.credit), 2);
        chk("pre_rst_slot",       {31'd0, dut.slot_valid},          1);
        rst = 1'b1;
        step(0, ALU, 0, 0, 0, 5'b00000, 0);
        chk("mid_rst_dec_ready",  {31'd0, dec_ready},  0);
        chk("mid_rst_disp_valid", {31'd0, disp_valid}, 0);
        adv();
        chk("mid_rst_slot",       {31'd0, dut.slot_valid},          0);
        chk("mid_rst_alu_credit", 32'(dut.g_rs[0].u_credit.credit), 8);
        chk("mid_rst_stall_cnt",  stall_cnt,                        0);
        rst = 1'b0;
        step(0, ALU, 0, 0, 0, 5'b00000, 0);
        chk("post_rst_dec_ready", {31'd0, dec_ready}, 1);
        adv();

        // Back-to-back jump_commit keeps the FSM in FLUSH for an extra cycle.
        step(0, ALU, 0, 0, 0, 5'b00000, 1);
        chk("jc1_cause", {29'd0, stall_cause}, {29'd0, C_NONE});
        adv();
        step(0, ALU, 0, 0, 0, 5'b00000, 1);
        chk("jc2_dec_ready", {31'd0, dec_ready}, 0);
        adv();
        step(0, ALU, 0, 0, 0, 5'b00000, 0);
        chk("jc3_dec_ready", {31'd0, dec_ready}, 0);
        adv();
        step(0, ALU, 0, 0, 0, 5'b00000, 0);
        chk("jc4_dec_ready", {31'd0, dec_ready}, 1);
        adv();

        chk("sb_drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
